// File: rtl/alu_serial_ctrl_if.sv
// Issue-side bus of the bit-serial ALU sequencer: request (start/op/a/b)
// from the issue stage, status and registered results back from the sequencer.
interface alu_serial_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             carry;
   logic             zero;
   logic             overflow;

   modport master (
      output start, op, a, b,
      input  busy, done, result, carry, zero, overflow
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, result, carry, zero, overflow
   );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: steps one alu_1bit slice over the operands LSB
// first, rippling carry through a register, and publishes result/flags once
// per operation. Optional feature macro: ALU_SERIAL_SLT_EN (op 111 = SLT).

// One-bit ALU slice. op[1:0]: 00 AND, 01 OR, 10 ADD (op[2] inverts b for SUB),
// 11 unsupported unless SLT is enabled, where 111 runs the subtract path.
module alu_1bit (
   input  logic       a,
   input  logic       b,
   input  logic       cin,
   input  logic [2:0] op,
   output logic       r,
   output logic       cout
);
   logic bx;

   // slice function select
   always_comb begin
      r    = 1'b0;
      cout = 1'b0;
      bx   = b ^ op[2];
      case (op[1:0])
         2'b00: r = a & b;
         2'b01: r = a | b;
         2'b10: begin
            r    = a ^ bx ^ cin;
            cout = (a & bx) | (a & cin) | (bx & cin);
         end
         default: begin
`ifdef ALU_SERIAL_SLT_EN
            if (op[2]) begin
               r    = a ^ bx ^ cin;
               cout = (a & bx) | (a & cin) | (bx & cin);
            end
`endif
         end
      endcase
   end
endmodule

module alu_serial_ctrl #(
   parameter int WIDTH = 8
) (
   input logic            clk,
   input logic            rst_n,
   alu_serial_ctrl_if.slave bus
);
   localparam int IW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_q, b_q, sh_q, sh_nxt, res_fin, result_q;
   logic [2:0]       op_q;
   logic [IW-1:0]    idx;
   logic             cr;
   logic             s_r, s_co;
   logic             accept, last;
   logic             ovf_fin;
   logic             carry_q, zero_q, ovf_q;

   assign accept = bus.start && (state != RUN);
   assign last   = (state == RUN) && (idx == IW'(WIDTH - 1));

   alu_1bit u_slice (
      .a    (a_q[idx]),
      .b    (b_q[idx]),
      .cin  (cr),
      .op   (op_q),
      .r    (s_r),
      .cout (s_co)
   );

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = RUN;
         RUN:     if (last) state_nxt = DONE;
         DONE:    state_nxt = bus.start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // final-bit assembly; carry into the MSB is still in cr on the last cycle
   always_comb begin
      sh_nxt      = sh_q;
      sh_nxt[idx] = s_r;
      res_fin     = sh_nxt;
      ovf_fin     = (op_q[1:0] == 2'b10) ? (cr ^ s_co) : 1'b0;
`ifdef ALU_SERIAL_SLT_EN
      if (op_q == 3'b111) begin
         res_fin    = '0;
         res_fin[0] = sh_nxt[WIDTH-1] ^ cr ^ s_co;
         ovf_fin    = 1'b0;
      end
`endif
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // operand capture and per-bit stepping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q  <= '0;
         b_q  <= '0;
         op_q <= '0;
         idx  <= '0;
         cr   <= 1'b0;
         sh_q <= '0;
      end else if (accept) begin
         a_q  <= bus.a;
         b_q  <= bus.b;
         op_q <= bus.op;
         idx  <= '0;
         cr   <= bus.op[2];
         sh_q <= '0;
      end else if (state == RUN) begin
         sh_q <= sh_nxt;
         cr   <= s_co;
         idx  <= last ? '0 : idx + IW'(1);
      end
   end

   // published result and flags, updated only on entry to DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else if (last) begin
         result_q <= res_fin;
         carry_q  <= s_co;
         zero_q   <= ~|res_fin;
         ovf_q    <= ovf_fin;
      end
   end

   assign bus.busy     = (state == RUN);
   assign bus.done     = (state == DONE);
   assign bus.result   = result_q;
   assign bus.carry    = carry_q;
   assign bus.zero     = zero_q;
   assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Scoreboard bench for alu_serial_ctrl (WIDTH=8): expected results are
// pushed when an operation is issued and popped when done is observed.
module tb_alu_serial_ctrl;
   typedef struct packed {
      logic [7:0] result;
      logic       carry;
      logic       zero;
      logic       overflow;
   } res_t;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   passed = 0;
   res_t sb[$];

   alu_serial_ctrl_if #(.WIDTH(8)) bus ();

   alu_serial_ctrl #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic res_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      res_t       r;
      logic [8:0] s;
      r = '0;
      s = '0;
      case (op)
         3'b000, 3'b100: r.result = a & b;
         3'b001, 3'b101: r.result = a | b;
         3'b010: begin
            s          = {1'b0, a} + {1'b0, b};
            r.result   = s[7:0];
            r.carry    = s[8];
            r.overflow = (a[7] == b[7]) && (s[7] != a[7]);
         end
         3'b110: begin
            s          = {1'b0, a} + {1'b0, ~b} + 9'd1;
            r.result   = s[7:0];
            r.carry    = s[8];
            r.overflow = (a[7] != b[7]) && (s[7] != a[7]);
         end
`ifdef ALU_SERIAL_SLT_EN
         3'b111: begin
            s        = {1'b0, a} + {1'b0, ~b} + 9'd1;
            r.result = {7'b0, ($signed(a) < $signed(b))};
            r.carry  = s[8];
         end
`endif
         default: ;
      endcase
      r.zero = (r.result == 8'h00);
      return r;
   endfunction

   function automatic string fmt(input res_t r);
      return $sformatf("r=%h c=%b z=%b v=%b", r.result, r.carry, r.zero, r.overflow);
   endfunction

   function automatic res_t observed();
      return {bus.result, bus.carry, bus.zero, bus.overflow};
   endfunction

   // drive a request at a negedge; returns at the negedge after the sampling edge
   task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      sb.push_back(model(op, a, b));
      @(negedge clk);
   endtask

   // cyc = edges since the start edge when done is seen; busy_n = busy samples before it
   task automatic wait_done(output int cyc, output int busy_n, output bit ok);
      cyc = 0; busy_n = 0; ok = 1'b0;
      while (cyc < 40) begin
         if (bus.done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         if (bus.busy === 1'b1) busy_n++;
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, observed()} !== 13'd0)
         $display("FAIL reset_outputs: busy=%b done=%b %s want all zero", bus.busy, bus.done, fmt(observed()));
      else passed++;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.busy, bus.done} !== 2'b00)
         $display("FAIL reset_idle: busy=%b done=%b want 0 0", bus.busy, bus.done);
      else passed++;
   endtask

   task automatic test_add_ovf();
      int cyc, bn; bit ok; res_t exp;
      issue(3'b010, 8'h7F, 8'h01);
      bus.start = 1'b0;
      wait_done(cyc, bn, ok);
      checks++;
      if (!ok || cyc != 8) $display("FAIL add_latency: done after %0d edges (seen=%0b) want 8", cyc, ok);
      else passed++;
      checks++;
      if (bn != 8) $display("FAIL add_busy_cycles: got %0d want 8", bn);
      else passed++;
      checks++;
      if (bus.busy !== 1'b0) $display("FAIL add_busy_in_done: got %b want 0", bus.busy);
      else passed++;
      exp = sb.pop_front();
      checks++;
      if (observed() !== exp) $display("FAIL add_7f_01: got %s want %s", fmt(observed()), fmt(exp));
      else passed++;
      @(negedge clk);
      checks++;
      if ({bus.done, observed()} !== {1'b0, exp})
         $display("FAIL add_hold_idle: done=%b %s want done=0 %s", bus.done, fmt(observed()), fmt(exp));
      else passed++;
   endtask

   task automatic test_sub_logic();
      logic [18:0] tbl [5] = '{{3'b110, 8'h05, 8'h05}, {3'b000, 8'hF0, 8'h3C},
                               {3'b001, 8'hF0, 8'h3C}, {3'b100, 8'hF0, 8'h3C},
                               {3'b101, 8'h0F, 8'h30}};
      int cyc, bn; bit ok; res_t exp;
      for (int i = 0; i < 5; i++) begin
         issue(tbl[i][18:16], tbl[i][15:8], tbl[i][7:0]);
         bus.start = 1'b0;
         wait_done(cyc, bn, ok);
         exp = sb.pop_front();
         checks++;
         if (!ok || observed() !== exp)
            $display("FAIL op_%b_%h_%h: seen=%0b got %s want %s", tbl[i][18:16], tbl[i][15:8], tbl[i][7:0], ok, fmt(observed()), fmt(exp));
         else passed++;
      end
   endtask

   task automatic test_ignore_start();
      int cyc, bn, extra; bit ok; res_t exp;
      issue(3'b010, 8'hFF, 8'h01);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h01;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(cyc, bn, ok);
      exp = sb.pop_front();
      checks++;
      if (!ok || observed() !== exp) $display("FAIL ignore_result: seen=%0b got %s want %s", ok, fmt(observed()), fmt(exp));
      else passed++;
      extra = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.done === 1'b1) extra++;
      end
      checks++;
      if (extra != 0) $display("FAIL ignore_single_done: extra done pulses %0d want 0", extra);
      else passed++;
   endtask

   task automatic test_reset_abort();
      int cyc, bn, dn; bit ok; res_t exp;
      issue(3'b010, 8'h0F, 8'h01);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.busy, bus.done, observed()} !== 13'd0)
         $display("FAIL abort_outputs: busy=%b done=%b %s want all zero", bus.busy, bus.done, fmt(observed()));
      else passed++;
      void'(sb.pop_back());
      @(negedge clk);
      rst_n = 1'b1;
      dn = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.done === 1'b1 || bus.busy === 1'b1) dn++;
      end
      checks++;
      if (dn != 0) $display("FAIL abort_stays_idle: busy/done cycles %0d want 0", dn);
      else passed++;
      issue(3'b010, 8'h0F, 8'h01);
      bus.start = 1'b0;
      wait_done(cyc, bn, ok);
      exp = sb.pop_front();
      checks++;
      if (!ok || observed() !== exp) $display("FAIL abort_rerun: seen=%0b got %s want %s", ok, fmt(observed()), fmt(exp));
      else passed++;
   endtask

   task automatic test_back_to_back();
      int cyc, cyc2, bn; bit ok, ok2; res_t exp;
      issue(3'b010, 8'h01, 8'h02);
      bus.op = 3'b110; bus.a = 8'h00; bus.b = 8'h01;
      sb.push_back(model(3'b110, 8'h00, 8'h01));
      wait_done(cyc, bn, ok);
      exp = sb.pop_front();
      checks++;
      if (!ok || cyc != 8 || observed() !== exp)
         $display("FAIL b2b_first: seen=%0b edges=%0d got %s want 8 %s", ok, cyc, fmt(observed()), fmt(exp));
      else passed++;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(cyc2, bn, ok2);
      checks++;
      if (!ok2 || cyc2 + 1 != 9) $display("FAIL b2b_spacing: done gap %0d (seen=%0b) want 9", cyc2 + 1, ok2);
      else passed++;
      exp = sb.pop_front();
      checks++;
      if (observed() !== exp) $display("FAIL b2b_second: got %s want %s", fmt(observed()), fmt(exp));
      else passed++;
   endtask

   task automatic test_op111();
      logic [18:0] tbl [3] = '{{3'b111, 8'hFF, 8'h01}, {3'b111, 8'h01, 8'hFF},
                               {3'b011, 8'hFF, 8'hFF}};
      int cyc, bn; bit ok; res_t exp;
      for (int i = 0; i < 3; i++) begin
         issue(tbl[i][18:16], tbl[i][15:8], tbl[i][7:0]);
         bus.start = 1'b0;
         wait_done(cyc, bn, ok);
         exp = sb.pop_front();
         checks++;
         if (!ok || observed() !== exp)
            $display("FAIL op_%b_%h_%h: seen=%0b got %s want %s", tbl[i][18:16], tbl[i][15:8], tbl[i][7:0], ok, fmt(observed()), fmt(exp));
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_add_ovf();
      test_sub_logic();
      test_ignore_start();
      test_reset_abort();
      test_back_to_back();
      test_op111();
      @(negedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, checks);
      $fatal(1);
   end
endmodule
